regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (wenable/reg_in/din) among NREQ
//  writeback sources (e.g. ALU, MEM, MUL). Round-robin arbitration, per-source
//  valid/ready handshake, one registered output stage driving the write port.
//  Sits between the writeback stages of the execution units and the register file.
// PARAMETERS
//  NREQ   3   number of writeback requesters (>=2)
//  N      5   register index width (2^N registers)
//  WIDTH  32  data width
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-low
//  req_valid  in   NREQ        requester i has a write pending
//  req_ready  out  NREQ        requester i accepted this cycle (one-hot or zero)
//  req_reg    in   NREQ*N      dest index, requester i at [i*N +: N]
//  req_data   in   NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//  hold       in   1           freeze: no grants, write port idle, stage kept
//  flush      in   1           sync clear of output stage, no grant this cycle
//  rf_wenable out  1           register-file write enable
//  rf_reg     out  N           register-file write index
//  rf_din     out  WIDTH       register-file write data
//  busy       out  1           output stage holds a valid, unissued write
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, out_reg=0, out_data=0, rr_ptr=0;
//    rf_wenable=0, rf_reg=0, rf_din=0, busy=0, req_ready=0.
//  - State: out_valid/out_reg/out_data (stage), rr_ptr in [0,NREQ-1].
//  - Grant (combinational): if flush|hold -> none. Else first i with req_valid[i]
//    searching rr_ptr, rr_ptr+1, ... mod NREQ. req_ready = one-hot grant.
//    req_ready depends on req_valid; requesters must not make valid depend on ready.
//  - Transfer on requester i when req_valid[i] & req_ready[i] at a clock edge.
//  - Edge update, priority flush > hold > normal:
//    flush: out_valid<=0; rr_ptr unchanged.
//    hold: stage unchanged; rr_ptr unchanged.
//    normal: grant i -> stage<={1,req_reg_i,req_data_i}, rr_ptr<=(i+1)%NREQ;
//            no grant -> out_valid<=0.
//  - rf_wenable = out_valid & ~hold; rf_reg/rf_din = stage fields.
//  - busy = out_valid & hold (write waiting on hold release).
//  - Latency: accepted at edge t -> rf_wenable high in cycle after edge t, one
//    cycle; register file commits at edge t+1. Throughput one write per cycle.
//  - Same dest from two requesters in one cycle: only one granted; other writes
//    on a later cycle, so final value is the later-granted requester's data.
//  - Hold with valid stage: write port idle, issued on first cycle hold=0.
//  - rr_ptr wrap: grant to NREQ-1 -> rr_ptr=0.
//  - Reset mid-operation: pending stage write discarded, never issued.
// CONFIGURATION
//  Macro WB_ZERO_FILTER_EN:
//  - Defined: request with req_reg==0 from the granted requester is accepted
//    (req_ready=1) but does not load the stage (out_valid<=0 if no other load)
//    and does not advance rr_ptr; arbitration then grants the next valid
//    nonzero-dest requester in the same cycle, both ready bits high (only case
//    where req_ready is not one-hot; at most one non-x0 grant).
//  - Undefined: x0 writes arbitrate and issue like any other; register file
//    discards them; one port slot consumed.
// TESTING
//  1 Reset: rst=0 with all valids high -> all outputs 0; after release rr_ptr=0.
//  2 Single: req_valid=3'b010, reg=5, data=32'hDEAD_BEEF -> ready=3'b010 same
//    cycle; next cycle rf_wenable=1, rf_reg=5, rf_din=DEADBEEF; then idle.
//  3 Round-robin: valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; rf_wenable
//    continuous from cycle 2.
//  4 Hold/flush: load write r7, hold=1 3 cycles -> rf_wenable=0, busy=1, no
//    ready; hold=0 -> r7 written once. Repeat with flush -> r7 never written.
//  5 Conflict: req0 r3=1, req1 r3=2 same cycle, rr_ptr=0 -> r3 written 1 then 2.
//  6 x0: req0 reg=0, req1 reg=4 -> with WB_ZERO_FILTER_EN ready=3'b011, only r4
//    issued, rr_ptr=2; without it ready=3'b001, r0 write issued, then r4.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// Optional build macro WB_ZERO_FILTER_EN: x0 writes are accepted but dropped before the output stage.
module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int N     = 5,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*N-1:0]     req_reg,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  rf_wenable,
  output logic [N-1:0]          rf_reg,
  output logic [WIDTH-1:0]      rf_din,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_reg_q,   out_reg_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [PW-1:0]    rr_ptr_q,    rr_ptr_d;

  logic [NREQ-1:0]  grant;
  logic             load;
  logic [N-1:0]     ld_reg;
  logic [WIDTH-1:0] ld_data;
  logic [PW-1:0]    ld_ptr;
`ifdef WB_ZERO_FILTER_EN
  logic             zero_taken;
`endif

  // Search starts at rr_ptr and wraps; at most one requester loads the stage.
  always_comb begin
    grant   = '0;
    load    = 1'b0;
    ld_reg  = '0;
    ld_data = '0;
    ld_ptr  = rr_ptr_q;
`ifdef WB_ZERO_FILTER_EN
    zero_taken = 1'b0;
`endif
    if (rst && !flush && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (((int'(rr_ptr_q) + k) % NREQ) == i && req_valid[i] && !load) begin
`ifdef WB_ZERO_FILTER_EN
            // Only the first-found x0 request is swallowed; later x0 requests wait.
            if (req_reg[i*N +: N] != '0) begin
              grant[i] = 1'b1;
              load     = 1'b1;
              ld_reg   = req_reg[i*N +: N];
              ld_data  = req_data[i*WIDTH +: WIDTH];
              ld_ptr   = PW'((i + 1) % NREQ);
            end else if (!zero_taken) begin
              grant[i]   = 1'b1;
              zero_taken = 1'b1;
            end
`else
            grant[i] = 1'b1;
            load     = 1'b1;
            ld_reg   = req_reg[i*N +: N];
            ld_data  = req_data[i*WIDTH +: WIDTH];
            ld_ptr   = PW'((i + 1) % NREQ);
`endif
          end
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_reg_d   = out_reg_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (!hold) begin
      out_valid_d = load;
      if (load) begin
        out_reg_d  = ld_reg;
        out_data_d = ld_data;
        rr_ptr_d   = ld_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready  = grant;
  assign rf_wenable = out_valid_q & ~hold;
  assign rf_reg     = out_reg_q;
  assign rf_din     = out_data_q;
  assign busy       = out_valid_q & hold;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// transaction-level reference (pending write, round-robin pointer, register-file write counts).
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int N    = 5;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_reg = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic              hold = 1'b0;
  logic              flush = 1'b0;
  logic              rf_wenable;
  logic [N-1:0]      rf_reg;
  logic [W-1:0]      rf_din;
  logic              busy;

  regfile_wb_arbiter #(.NREQ(NREQ), .N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .hold(hold), .flush(flush),
    .rf_wenable(rf_wenable), .rf_reg(rf_reg), .rf_din(rf_din), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference: the single pending write and the next requester to favour.
  bit          m_valid;
  int          m_reg;
  logic [31:0] m_data;
  int          m_ptr;

  int          wcnt[32];
  logic [31:0] dut_rf[32];

  always @(posedge clk) begin
    if (rst && rf_wenable) begin
      dut_rf[rf_reg] = rf_din;
      wcnt[rf_reg]   = wcnt[rf_reg] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 32; i++) wcnt[i] = 0;
  endtask

  // Who should be granted given requests and the model's pointer.
  task automatic m_grant(input logic [2:0] v, input logic [14:0] r, input logic h, input logic f,
                         output logic [2:0] g, output int li);
    g  = '0;
    li = -1;
    if (!(f || h)) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (v[i] && li < 0) begin
`ifdef WB_ZERO_FILTER_EN
          if (r[i*N +: N] != 5'd0) begin
            g[i] = 1'b1;
            li   = i;
          end else if (g == 3'b000) begin
            g[i] = 1'b1;
          end
`else
          g[i] = 1'b1;
          li   = i;
`endif
        end
      end
    end
  endtask

  task automatic step(input logic [2:0] v, input logic [14:0] r, input logic [95:0] d,
                      input logic h, input logic f, output logic [2:0] rdy);
    logic [2:0] eg;
    int li;
    req_valid = v; req_reg = r; req_data = d; hold = h; flush = f;
    #2;
    m_grant(v, r, h, f, eg, li);
    rdy = req_ready;
    chk("ready", req_ready, eg);
    chk("wen",   rf_wenable, m_valid && !h);
    chk("reg",   rf_reg, m_reg);
    chk("din",   rf_din, m_data);
    chk("busy",  busy, m_valid && h);
    @(posedge clk);
    if (f) m_valid = 0;
    else if (!h) begin
      if (li >= 0) begin
        m_valid = 1;
        m_reg   = int'(r[li*N +: N]);
        m_data  = d[li*W +: W];
        m_ptr   = (li + 1) % NREQ;
      end else m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '1; hold = 1'b0; flush = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_wen",   rf_wenable, 1'b0);
    chk("rst_reg",   rf_reg, 5'd0);
    chk("rst_din",   rf_din, 32'd0);
    chk("rst_busy",  busy, 1'b0);
    m_valid = 0; m_reg = 0; m_data = '0; m_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [2:0]  rdy;
  logic [14:0] rr;
  logic [95:0] dd;
`ifdef WB_ZERO_FILTER_EN
  localparam logic [2:0] X0_READY  = 3'b011;
  localparam logic [2:0] X0_SECOND = 3'b000;
  localparam int         X0_WRITES = 0;
`else
  localparam logic [2:0] X0_READY  = 3'b001;
  localparam logic [2:0] X0_SECOND = 3'b010;
  localparam int         X0_WRITES = 1;
`endif

  initial begin
    clear_counts();
    @(negedge clk);
    do_reset();

    // Single write from requester 1.
    step(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 1'b0, 1'b0, rdy);
    chk("t2_ready", rdy, 3'b010);
    chk("t2_wen",   rf_wenable, 1'b1);
    chk("t2_reg",   rf_reg, 5'd5);
    chk("t2_din",   rf_din, 32'hDEAD_BEEF);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    chk("t2_idle",  rf_wenable, 1'b0);

    // Round-robin across all three requesters.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0, rdy);
      chk("t3_rr",  rdy, 3'b001 << (k % 3));
      chk("t3_wen", rf_wenable, 1'b1);
    end
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);

    // Hold keeps r7 pending, then it issues exactly once.
    clear_counts();
    step(3'b001, {5'd1, 5'd1, 5'd7}, {32'h1, 32'h1, 32'hAAAA_0007}, 1'b0, 1'b0, rdy);
    for (int k = 0; k < 3; k++) step(3'b111, {5'd1, 5'd1, 5'd1}, '0, 1'b1, 1'b0, rdy);
    chk("t4_busy", busy, 1'b1);
    chk("t4_w7_held", wcnt[7], 0);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    chk("t4_w7_once", wcnt[7], 1);
    chk("t4_r7", dut_rf[7], 32'hAAAA_0007);

    // Flush while held discards r7.
    clear_counts();
    step(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hBBBB_0007}, 1'b0, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b1, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b1, 1'b1, rdy);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    chk("t4_flush_w7", wcnt[7], 0);

    // Same destination from two requesters.
    do_reset();
    clear_counts();
    step(3'b011, {5'd0, 5'd3, 5'd3}, {32'h0, 32'h2, 32'h1}, 1'b0, 1'b0, rdy);
    chk("t5_first", rdy, 3'b001);
    step(3'b010, {5'd0, 5'd3, 5'd3}, {32'h0, 32'h2, 32'h1}, 1'b0, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    chk("t5_cnt", wcnt[3], 2);
    chk("t5_r3",  dut_rf[3], 32'h2);

    // x0 destination.
    do_reset();
    clear_counts();
    step(3'b011, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h99}, 1'b0, 1'b0, rdy);
    chk("t6_ready", rdy, X0_READY);
    step(X0_SECOND, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h99}, 1'b0, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    step(3'b000, '0, '0, 1'b0, 1'b0, rdy);
    chk("t6_r4", wcnt[4], 1);
    chk("t6_r0", wcnt[0], X0_WRITES);

    // Random traffic, including occasional mid-operation resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          rr[i*N +: N] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
          dd[i*W +: W] = $urandom;
        end
        step(3'($urandom), rr, dd, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, rdy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
